memory_access_stage: RTL and testbench

- MEM stage of the 5-stage pipeline: consumer side of the execute/memory pipeline register.
- Takes the registered EX/MEM control and data bundle and runs load/store transactions on the data-memory req/ack bus.
- Selects the write-back value and drives the registered MEM/WB bundle.
- Stalls upstream stages while a memory access is outstanding; reports misaligned accesses and bus timeouts.

---
 rtl/memory_access_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_memory_access_stage.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// MEM stage: consumes the EX/MEM bundle, runs load/store transactions on the
// data-memory req/ack bus and drives the registered MEM/WB bundle.
module memory_access_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        em_reg_write_i,
    input  logic        em_mem_read_i,
    input  logic        em_mem_write_i,
    input  logic [1:0]  em_dmem_to_reg_i,
    input  logic [2:0]  em_funct3_i,
    input  logic [31:0] em_pc_new_i,
    input  logic [4:0]  em_write_addr_reg_i,
    input  logic [31:0] em_alu_result_i,
    input  logic [31:0] em_read_data2_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        mw_reg_write_o,
    output logic [4:0]  mw_write_addr_reg_o,
    output logic [31:0] mw_wb_data_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    typedef enum logic [0:0] {IDLE, ACCESS} state_t;

    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Transaction registers captured when an access is launched
    logic [31:0] addr_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic        reg_write_q;
    logic [4:0]  rd_q;
    logic [1:0]  wb_sel_q;

    logic        mem_op;
    logic        size_byte;
    logic        size_half;
    logic        aligned;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic        timeout_hit;
    logic        latch_en;

    logic        mw_reg_write_d;
    logic [4:0]  mw_rd_d;
    logic [31:0] mw_wb_d;
    logic        misalign_d;
    logic        bus_err_d;

    // Pick the byte/half addressed by the low address bits and extend it;
    // any size code that is not B/H/BU/HU returns the whole word.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
        logic [31:0] shifted;
        shifted = word >> {off, 3'b000};
        case (f3)
            3'b000:  load_extract = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_extract = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_extract = {24'b0, shifted[7:0]};
            3'b101:  load_extract = {16'b0, shifted[15:0]};
            default: load_extract = word;
        endcase
    endfunction

    function automatic logic [31:0] wb_select(input logic [1:0]  sel,
                                              input logic [31:0] alu,
                                              input logic [31:0] ld,
                                              input logic [31:0] pc);
        case (sel)
            2'd1:    wb_select = ld;
            2'd2:    wb_select = pc;
            default: wb_select = alu;
        endcase
    endfunction

    assign mem_op    = em_mem_read_i | em_mem_write_i;
    assign size_byte = (em_funct3_i[1:0] == 2'b00);
    assign size_half = (em_funct3_i[1:0] == 2'b01);
    assign aligned   = size_byte
                     | (size_half & ~em_alu_result_i[0])
                     | (~size_byte & ~size_half & (em_alu_result_i[1:0] == 2'b00));
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Byte enables and lane-replicated store data for the incoming access
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = em_read_data2_i;
        if (size_byte) begin
            be_new    = 4'b0001 << em_alu_result_i[1:0];
            wdata_new = {4{em_read_data2_i[7:0]}};
        end else if (size_half) begin
            be_new    = 4'b0011 << {em_alu_result_i[1], 1'b0};
            wdata_new = {2{em_read_data2_i[15:0]}};
        end
    end

    // Next-state, stall and MEM/WB next-value logic; a bubble is the default
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        stall_o        = 1'b0;
        latch_en       = 1'b0;
        mw_reg_write_d = 1'b0;
        mw_rd_d        = 5'd0;
        mw_wb_d        = 32'd0;
        misalign_d     = 1'b0;
        bus_err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (mem_op) begin
                    if (aligned) begin
                        stall_o  = 1'b1;
                        latch_en = 1'b1;
                        state_d  = ACCESS;
                    end else begin
                        misalign_d = 1'b1;
                    end
                end else begin
                    mw_reg_write_d = em_reg_write_i;
                    mw_rd_d        = em_write_addr_reg_i;
                    mw_wb_d        = wb_select(em_dmem_to_reg_i, em_alu_result_i,
                                               load_extract(dmem_rdata_i, em_funct3_i,
                                                            em_alu_result_i[1:0]),
                                               em_pc_new_i);
                end
            end
            ACCESS: begin
                if (dmem_ack_i) begin
                    state_d        = IDLE;
                    cnt_d          = '0;
                    mw_reg_write_d = reg_write_q & ~we_q;
                    mw_rd_d        = rd_q;
                    mw_wb_d        = wb_select(wb_sel_q, addr_q,
                                               load_extract(dmem_rdata_i, funct3_q,
                                                            addr_q[1:0]),
                                               em_pc_new_i);
                end else if (timeout_hit) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    bus_err_d = 1'b1;
                end else begin
                    stall_o = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and timeout counter
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the transaction so the bus stays stable for the whole access
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            addr_q      <= 32'd0;
            we_q        <= 1'b0;
            be_q        <= 4'd0;
            wdata_q     <= 32'd0;
            funct3_q    <= 3'd0;
            reg_write_q <= 1'b0;
            rd_q        <= 5'd0;
            wb_sel_q    <= 2'd0;
        end else if (latch_en) begin
            addr_q      <= em_alu_result_i;
            we_q        <= em_mem_write_i;
            be_q        <= be_new;
            wdata_q     <= wdata_new;
            funct3_q    <= em_funct3_i;
            reg_write_q <= em_reg_write_i;
            rd_q        <= em_write_addr_reg_i;
            wb_sel_q    <= em_dmem_to_reg_i;
        end
    end

    // MEM/WB register and the single-cycle error pulses
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mw_reg_write_o      <= 1'b0;
            mw_write_addr_reg_o <= 5'd0;
            mw_wb_data_o        <= 32'd0;
            misalign_o          <= 1'b0;
            bus_err_o           <= 1'b0;
        end else begin
            mw_reg_write_o      <= mw_reg_write_d;
            mw_write_addr_reg_o <= mw_rd_d;
            mw_wb_data_o        <= mw_wb_d;
            misalign_o          <= misalign_d;
            bus_err_o           <= bus_err_d;
        end
    end

    assign dmem_req_o   = (state_q == ACCESS);
    assign dmem_we_o    = dmem_req_o & we_q;
    assign dmem_addr_o  = {addr_q[31:2], 2'b00};
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: table of single-cycle vectors
// plus hand-written multi-cycle load/store, timeout and reset sequences.
module tb_memory_access_stage;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        em_reg_write_i;
    logic        em_mem_read_i;
    logic        em_mem_write_i;
    logic [1:0]  em_dmem_to_reg_i;
    logic [2:0]  em_funct3_i;
    logic [31:0] em_pc_new_i;
    logic [4:0]  em_write_addr_reg_i;
    logic [31:0] em_alu_result_i;
    logic [31:0] em_read_data2_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o;
    logic        mw_reg_write_o;
    logic [4:0]  mw_write_addr_reg_o;
    logic [31:0] mw_wb_data_o;
    logic        misalign_o;
    logic        bus_err_o;

    memory_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk_i               (clk_i),
        .reset_i             (reset_i),
        .em_reg_write_i      (em_reg_write_i),
        .em_mem_read_i       (em_mem_read_i),
        .em_mem_write_i      (em_mem_write_i),
        .em_dmem_to_reg_i    (em_dmem_to_reg_i),
        .em_funct3_i         (em_funct3_i),
        .em_pc_new_i         (em_pc_new_i),
        .em_write_addr_reg_i (em_write_addr_reg_i),
        .em_alu_result_i     (em_alu_result_i),
        .em_read_data2_i     (em_read_data2_i),
        .dmem_req_o          (dmem_req_o),
        .dmem_we_o           (dmem_we_o),
        .dmem_addr_o         (dmem_addr_o),
        .dmem_be_o           (dmem_be_o),
        .dmem_wdata_o        (dmem_wdata_o),
        .dmem_ack_i          (dmem_ack_i),
        .dmem_rdata_i        (dmem_rdata_i),
        .stall_o             (stall_o),
        .mw_reg_write_o      (mw_reg_write_o),
        .mw_write_addr_reg_o (mw_write_addr_reg_o),
        .mw_wb_data_o        (mw_wb_data_o),
        .misalign_o          (misalign_o),
        .bus_err_o           (bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        mr;
        logic        mw;
        logic [2:0]  f3;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] expWb;
        logic        expRw;
        logic        expStall;
        logic        expMis;
        logic        chkData;
    } vec_t;

    vec_t vecs[10];

    int checks = 0;
    int passes = 0;

    int          stallCnt;
    int          reqCnt;
    logic [3:0]  capBe;
    logic [31:0] capAddr;
    logic [31:0] capWdata;
    logic        capWe;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    task automatic setEm(input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] rd2, input logic [31:0] pc,
                         input logic [4:0] rd, input logic rw);
        em_mem_read_i       = mr;
        em_mem_write_i      = mw;
        em_funct3_i         = f3;
        em_dmem_to_reg_i    = sel;
        em_alu_result_i     = alu;
        em_read_data2_i     = rd2;
        em_pc_new_i         = pc;
        em_write_addr_reg_i = rd;
        em_reg_write_i      = rw;
    endtask

    task automatic clearEm();
        setEm(1'b0, 1'b0, 3'b000, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    task automatic applyStimulus(input vec_t v);
        setEm(v.mr, v.mw, v.f3, v.sel, v.alu, v.rd2, v.pc, v.rd, v.rw);
    endtask

    // Called at posedge+1 with a mem op already on the EX/MEM inputs. Acts as
    // the memory: acks on the (ackAfter+1)-th request cycle, never if negative.
    task automatic runAccess(input string name, input int ackAfter,
                             input logic [31:0] rdata);
        int   accessCnt;
        logic done;
        logic bubbleBad;
        logic captured;
        accessCnt = 0;
        done      = 1'b0;
        bubbleBad = 1'b0;
        captured  = 1'b0;
        stallCnt  = 0;
        reqCnt    = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0 && mw_reg_write_o !== 1'b0) bubbleBad = 1'b1;
            if (dmem_req_o) begin
                dmem_ack_i   = (ackAfter >= 0) && (accessCnt == ackAfter);
                dmem_rdata_i = dmem_ack_i ? rdata : 32'hDEAD_BEEF;
                accessCnt++;
            end else begin
                dmem_ack_i = 1'b0;
            end
            #4;
            if (stall_o) stallCnt++;
            if (dmem_req_o) begin
                reqCnt++;
                if (!captured) begin
                    captured = 1'b1;
                    capBe    = dmem_be_o;
                    capAddr  = dmem_addr_o;
                    capWdata = dmem_wdata_o;
                    capWe    = dmem_we_o;
                end
            end
            if (!stall_o) done = 1'b1;
            @(posedge clk_i);
            #1;
        end
        dmem_ack_i = 1'b0;
        checkOutput({name, "_finished"}, 32'(done), 32'd1);
        checkOutput({name, "_bubbles"}, 32'(bubbleBad), 32'd0);
    endtask

    initial begin
        // Single-cycle behaviour: ALU ops with each write-back select, and
        // misaligned accesses that must not touch the bus.
        vecs[0] = '{1'b0, 1'b0, 3'b010, 2'd0, 32'h0000_1234, 32'd0, 32'h1004, 5'd5,  1'b1, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 3'b010, 2'd2, 32'h0000_0055, 32'd0, 32'h1004, 5'd1,  1'b1, 32'h0000_1004, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 3'b010, 2'd3, 32'hCAFE_F00D, 32'd0, 32'h1004, 5'd31, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 3'b000, 2'd0, 32'h0000_0099, 32'd0, 32'h1004, 5'd7,  1'b0, 32'h0000_0099, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 3'b010, 2'd1, 32'h0000_0101, 32'd0, 32'h1004, 5'd8,  1'b1, 32'd0,         1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 3'b001, 2'd1, 32'h0000_0103, 32'd0, 32'h1004, 5'd8,  1'b1, 32'd0,         1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 3'b010, 2'd0, 32'h0000_0102, 32'hFFFF, 32'h1004, 5'd0, 1'b0, 32'd0,      1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 3'b101, 2'd1, 32'h0000_0001, 32'd0, 32'h1004, 5'd9,  1'b1, 32'd0,         1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 3'b110, 2'd1, 32'h0000_0002, 32'd0, 32'h1004, 5'd9,  1'b1, 32'd0,         1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 3'b010, 2'd0, 32'h0000_0000, 32'd0, 32'h1004, 5'd0,  1'b1, 32'd0,         1'b1, 1'b0, 1'b0, 1'b1};

        reset_i      = 1'b1;
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = 32'd0;
        clearEm();
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("rst_req",      32'(dmem_req_o),          32'd0);
        checkOutput("rst_stall",    32'(stall_o),             32'd0);
        checkOutput("rst_mw_rw",    32'(mw_reg_write_o),      32'd0);
        checkOutput("rst_mw_rd",    32'(mw_write_addr_reg_o), 32'd0);
        checkOutput("rst_mw_wb",    mw_wb_data_o,             32'd0);
        checkOutput("rst_misalign", 32'(misalign_o),          32'd0);
        checkOutput("rst_bus_err",  32'(bus_err_o),           32'd0);
        reset_i = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            #4;
            checkOutput($sformatf("vec%0d_stall", i), 32'(stall_o),    32'(vecs[i].expStall));
            checkOutput($sformatf("vec%0d_req", i),   32'(dmem_req_o), 32'd0);
            @(posedge clk_i);
            #1;
            checkOutput($sformatf("vec%0d_mw_rw", i),    32'(mw_reg_write_o), 32'(vecs[i].expRw));
            checkOutput($sformatf("vec%0d_misalign", i), 32'(misalign_o),     32'(vecs[i].expMis));
            if (vecs[i].chkData) begin
                checkOutput($sformatf("vec%0d_mw_wb", i), mw_wb_data_o,             vecs[i].expWb);
                checkOutput($sformatf("vec%0d_mw_rd", i), 32'(mw_write_addr_reg_o), 32'(vecs[i].rd));
            end
        end

        // LB at 0x103, ack on the fourth ACCESS cycle
        setEm(1'b1, 1'b0, 3'b000, 2'd1, 32'h0000_0103, 32'd0, 32'h1004, 5'd9, 1'b1);
        runAccess("lb", 3, 32'h80FF_0000);
        checkOutput("lb_stall_cycles", 32'(stallCnt), 32'd4);
        checkOutput("lb_req_cycles",   32'(reqCnt),   32'd4);
        checkOutput("lb_be",           32'(capBe),    32'h8);
        checkOutput("lb_addr",         capAddr,       32'h0000_0100);
        checkOutput("lb_we",           32'(capWe),    32'd0);
        checkOutput("lb_mw_wb",        mw_wb_data_o,  32'hFFFF_FF80);
        checkOutput("lb_mw_rw",        32'(mw_reg_write_o),      32'd1);
        checkOutput("lb_mw_rd",        32'(mw_write_addr_reg_o), 32'd9);
        clearEm();

        // SH at 0x202, minimum-latency ack; stores never write a register
        setEm(1'b0, 1'b1, 3'b001, 2'd0, 32'h0000_0202, 32'h1234_ABCD, 32'h1004, 5'd4, 1'b1);
        runAccess("sh", 0, 32'd0);
        checkOutput("sh_stall_cycles", 32'(stallCnt), 32'd1);
        checkOutput("sh_addr",         capAddr,       32'h0000_0200);
        checkOutput("sh_be",           32'(capBe),    32'hC);
        checkOutput("sh_wdata",        capWdata,      32'hABCD_ABCD);
        checkOutput("sh_we",           32'(capWe),    32'd1);
        checkOutput("sh_mw_rw",        32'(mw_reg_write_o), 32'd0);
        clearEm();

        // SB at 0x001
        setEm(1'b0, 1'b1, 3'b000, 2'd0, 32'h0000_0001, 32'h0000_3377, 32'h1004, 5'd4, 1'b0);
        runAccess("sb", 0, 32'd0);
        checkOutput("sb_be",    32'(capBe), 32'h2);
        checkOutput("sb_wdata", capWdata,   32'h7777_7777);
        clearEm();

        // LHU at 0x102
        setEm(1'b1, 1'b0, 3'b101, 2'd1, 32'h0000_0102, 32'd0, 32'h1004, 5'd10, 1'b1);
        runAccess("lhu", 1, 32'h8001_0000);
        checkOutput("lhu_stall_cycles", 32'(stallCnt), 32'd2);
        checkOutput("lhu_be",           32'(capBe),    32'hC);
        checkOutput("lhu_mw_wb",        mw_wb_data_o,  32'h0000_8001);
        checkOutput("lhu_mw_rd",        32'(mw_write_addr_reg_o), 32'd10);
        clearEm();

        // LH at 0x106 sign-extends
        setEm(1'b1, 1'b0, 3'b001, 2'd1, 32'h0000_0106, 32'd0, 32'h1004, 5'd11, 1'b1);
        runAccess("lh", 0, 32'h8001_0000);
        checkOutput("lh_mw_wb", mw_wb_data_o, 32'hFFFF_8001);
        clearEm();

        // LW at 0x104
        setEm(1'b1, 1'b0, 3'b010, 2'd1, 32'h0000_0104, 32'd0, 32'h1004, 5'd12, 1'b1);
        runAccess("lw", 0, 32'h1234_5678);
        checkOutput("lw_be",    32'(capBe), 32'hF);
        checkOutput("lw_addr",  capAddr,    32'h0000_0104);
        checkOutput("lw_mw_wb", mw_wb_data_o, 32'h1234_5678);
        clearEm();

        // Ack while idle is ignored
        dmem_ack_i = 1'b1;
        #4;
        checkOutput("idle_ack_req",   32'(dmem_req_o), 32'd0);
        checkOutput("idle_ack_stall", 32'(stall_o),    32'd0);
        @(posedge clk_i);
        #1;
        dmem_ack_i = 1'b0;

        // Load that is never acknowledged times out
        setEm(1'b1, 1'b0, 3'b010, 2'd1, 32'h0000_0300, 32'd0, 32'h1004, 5'd13, 1'b1);
        runAccess("to", -1, 32'd0);
        checkOutput("to_req_cycles",   32'(reqCnt),   32'(TO));
        checkOutput("to_stall_cycles", 32'(stallCnt), 32'(TO));
        checkOutput("to_bus_err",      32'(bus_err_o),      32'd1);
        checkOutput("to_mw_rw",        32'(mw_reg_write_o), 32'd0);
        clearEm();
        @(posedge clk_i);
        #1;
        checkOutput("to_bus_err_pulse", 32'(bus_err_o), 32'd0);
        checkOutput("to_req_idle",      32'(dmem_req_o), 32'd0);

        // Reset in the middle of an access abandons it at once
        setEm(1'b1, 1'b0, 3'b010, 2'd1, 32'h0000_0300, 32'd0, 32'h1004, 5'd14, 1'b1);
        @(posedge clk_i);
        #1;
        checkOutput("mid_req_before", 32'(dmem_req_o), 32'd1);
        #2;
        reset_i = 1'b1;
        clearEm();
        #1;
        checkOutput("mid_rst_req",   32'(dmem_req_o),     32'd0);
        checkOutput("mid_rst_stall", 32'(stall_o),        32'd0);
        checkOutput("mid_rst_we",    32'(dmem_we_o),      32'd0);
        checkOutput("mid_rst_be",    32'(dmem_be_o),      32'd0);
        checkOutput("mid_rst_addr",  dmem_addr_o,         32'd0);
        checkOutput("mid_rst_mw_rw", 32'(mw_reg_write_o), 32'd0);
        checkOutput("mid_rst_mw_wb", mw_wb_data_o,        32'd0);
        checkOutput("mid_rst_err",   32'(bus_err_o | misalign_o), 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        @(posedge clk_i);
        #1;
        checkOutput("post_rst_req", 32'(dmem_req_o), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
